// File: rtl/multi_watermark_counter_pkg.sv
// Shared types for the multi-channel watermark counter.
// Counts are held internally at MAX_WIDTH bits. Channels mask their arithmetic
// to their own WIDTH, so the upper bits always stay zero.
// WIDTH is supported up to MAX_WIDTH.
package multi_watermark_counter_pkg;

  localparam int unsigned MAX_WIDTH = 32;

  typedef logic [MAX_WIDTH-1:0] cnt_t;

  // Complete registered state of one counter channel
  typedef struct packed {
    cnt_t q;
    cnt_t max;
    cnt_t min;
    logic ovf;
    logic udf;
    logic alarm;
  } ch_state_t;

  // All-ones value of a counter that is 'width' bits wide
  function automatic cnt_t width_mask(input int unsigned width);
    width_mask = cnt_t'((64'd1 << width) - 64'd1);
  endfunction

endpackage

// File: rtl/watermark_channel.sv
// One counter channel.
// It provides:
//   - clear, load and up/down counting with priority in that order;
//   - wrap or saturate on carry/borrow;
//   - high and low watermarks;
//   - a sticky threshold alarm.
module watermark_channel #(
  parameter int   WIDTH           = 8,
  parameter logic SATURATE        = 1'b0,
  parameter logic STICKY_OVERFLOW = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             load,
  input  logic             en,
  input  logic             down,
  input  logic             clear_wm,
  input  logic             alarm_clr,
  input  logic [WIDTH-1:0] delta,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] thresh,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] max,
  output logic [WIDTH-1:0] min,
  output logic             overflow,
  output logic             underflow,
  output logic             alarm
);
  import multi_watermark_counter_pkg::*;

  localparam cnt_t MASK = width_mask(WIDTH);

  ch_state_t state;
  ch_state_t state_next;
  cnt_t      q_d;
  cnt_t      delta_w;
  cnt_t      d_w;
  cnt_t      thresh_w;
  logic      carry;
  logic      borrow;

  assign delta_w  = cnt_t'(delta);
  assign d_w      = cnt_t'(d);
  assign thresh_w = cnt_t'(thresh);

  // Next count: clear beats load beats count; carry/borrow detected by comparison against headroom
  always_comb begin
    q_d    = state.q;
    carry  = 1'b0;
    borrow = 1'b0;
    if (clear) begin
      q_d = '0;
    end else if (load) begin
      q_d = d_w;
    end else if (en) begin
      if (down) begin
        borrow = delta_w > state.q;
        q_d    = (state.q - delta_w) & MASK;
        if (SATURATE && borrow) q_d = '0;
      end else begin
        carry = delta_w > (MASK - state.q);
        q_d   = (state.q + delta_w) & MASK;
        if (SATURATE && carry) q_d = MASK;
      end
    end
  end

  // Flags, watermarks and alarm all track q_d so they move on the same edge as the count
  always_comb begin
    state_next   = state;
    state_next.q = q_d;
    if (clear || load) begin
      state_next.ovf = 1'b0;
      state_next.udf = 1'b0;
    end else if (STICKY_OVERFLOW) begin
      state_next.ovf = state.ovf | carry;
      state_next.udf = state.udf | borrow;
    end else begin
      state_next.ovf = carry;
      state_next.udf = borrow;
    end
    if (clear_wm) begin
      state_next.max = q_d;
      state_next.min = q_d;
    end else begin
      state_next.max = (q_d > state.max) ? q_d : state.max;
      state_next.min = (q_d < state.min) ? q_d : state.min;
    end
    state_next.alarm = (q_d >= thresh_w) | (state.alarm & ~alarm_clr);
  end

  // Channel state register with synchronous reset overriding every other input
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= '0;
    end else begin
      state <= state_next;
    end
  end

  assign q         = state.q[WIDTH-1:0];
  assign max       = state.max[WIDTH-1:0];
  assign min       = state.min[WIDTH-1:0];
  assign overflow  = state.ovf;
  assign underflow = state.udf;
  assign alarm     = state.alarm;

endmodule

// File: rtl/multi_watermark_counter.sv
// NUM_CH independent watermark counters sharing one clock and reset.
// Per-channel vectors are packed flat, with channel i at bits [i*WIDTH +: WIDTH].
module multi_watermark_counter #(
  parameter int   NUM_CH          = 4,
  parameter int   WIDTH           = 8,
  parameter logic SATURATE        = 1'b0,
  parameter logic STICKY_OVERFLOW = 1'b1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NUM_CH-1:0]       clear_i,
  input  logic [NUM_CH-1:0]       load_i,
  input  logic [NUM_CH-1:0]       en_i,
  input  logic [NUM_CH-1:0]       down_i,
  input  logic [NUM_CH-1:0]       clear_wm_i,
  input  logic [NUM_CH*WIDTH-1:0] delta_i,
  input  logic [NUM_CH*WIDTH-1:0] d_i,
  input  logic [NUM_CH*WIDTH-1:0] thresh_i,
  input  logic [NUM_CH-1:0]       alarm_clr_i,
  output logic [NUM_CH*WIDTH-1:0] q_o,
  output logic [NUM_CH*WIDTH-1:0] max_o,
  output logic [NUM_CH*WIDTH-1:0] min_o,
  output logic [NUM_CH-1:0]       overflow_o,
  output logic [NUM_CH-1:0]       underflow_o,
  output logic [NUM_CH-1:0]       alarm_o
);
  import multi_watermark_counter_pkg::*;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    watermark_channel #(
      .WIDTH          (WIDTH),
      .SATURATE       (SATURATE),
      .STICKY_OVERFLOW(STICKY_OVERFLOW)
    ) u_ch (
      .clk      (clk_i),
      .rst      (rst_i),
      .clear    (clear_i[i]),
      .load     (load_i[i]),
      .en       (en_i[i]),
      .down     (down_i[i]),
      .clear_wm (clear_wm_i[i]),
      .alarm_clr(alarm_clr_i[i]),
      .delta    (delta_i[i*WIDTH +: WIDTH]),
      .d        (d_i[i*WIDTH +: WIDTH]),
      .thresh   (thresh_i[i*WIDTH +: WIDTH]),
      .q        (q_o[i*WIDTH +: WIDTH]),
      .max      (max_o[i*WIDTH +: WIDTH]),
      .min      (min_o[i*WIDTH +: WIDTH]),
      .overflow (overflow_o[i]),
      .underflow(underflow_o[i]),
      .alarm    (alarm_o[i])
    );
  end

endmodule

// File: tb/tb_multi_watermark_counter.sv
// Directed bench for multi_watermark_counter.
// It uses three instances of the counter:
//   - dut_w: wrapping, sticky flags;
//   - dut_s: saturating, sticky flags;
//   - dut_p: wrapping, pulsed flags.
// All three share the same inputs.
module tb_multi_watermark_counter;

  localparam int NUM_CH = 4;
  localparam int WIDTH  = 8;

  logic                    clk_i = 1'b0;
  logic                    rst_i;
  logic [NUM_CH-1:0]       clear_i, load_i, en_i, down_i, clear_wm_i, alarm_clr_i;
  logic [NUM_CH*WIDTH-1:0] delta_i, d_i, thresh_i;

  logic [NUM_CH*WIDTH-1:0] q_w, max_w, min_w, q_s, max_s, min_s, q_p, max_p, min_p;
  logic [NUM_CH-1:0]       ovf_w, udf_w, alarm_w, ovf_s, udf_s, alarm_s, ovf_p, udf_p, alarm_p;

  int num_checks = 0;
  int num_fails  = 0;

  typedef struct {
    logic       rst, clear, load, en, down, clear_wm, alarm_clr;
    logic [7:0] delta, d, thresh;
    logic [7:0] exp_q, exp_max, exp_min;
    logic       exp_ovf, exp_udf, exp_alarm;
  } vec_t;

  vec_t vecs[$];

  multi_watermark_counter #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .SATURATE(1'b0), .STICKY_OVERFLOW(1'b1)) dut_w (
    .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i), .load_i(load_i), .en_i(en_i), .down_i(down_i),
    .clear_wm_i(clear_wm_i), .delta_i(delta_i), .d_i(d_i), .thresh_i(thresh_i), .alarm_clr_i(alarm_clr_i),
    .q_o(q_w), .max_o(max_w), .min_o(min_w), .overflow_o(ovf_w), .underflow_o(udf_w), .alarm_o(alarm_w));

  multi_watermark_counter #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .SATURATE(1'b1), .STICKY_OVERFLOW(1'b1)) dut_s (
    .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i), .load_i(load_i), .en_i(en_i), .down_i(down_i),
    .clear_wm_i(clear_wm_i), .delta_i(delta_i), .d_i(d_i), .thresh_i(thresh_i), .alarm_clr_i(alarm_clr_i),
    .q_o(q_s), .max_o(max_s), .min_o(min_s), .overflow_o(ovf_s), .underflow_o(udf_s), .alarm_o(alarm_s));

  multi_watermark_counter #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .SATURATE(1'b0), .STICKY_OVERFLOW(1'b0)) dut_p (
    .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i), .load_i(load_i), .en_i(en_i), .down_i(down_i),
    .clear_wm_i(clear_wm_i), .delta_i(delta_i), .d_i(d_i), .thresh_i(thresh_i), .alarm_clr_i(alarm_clr_i),
    .q_o(q_p), .max_o(max_p), .min_o(min_p), .overflow_o(ovf_p), .underflow_o(udf_p), .alarm_o(alarm_p));

  // Free-running clock, 10 time units per period
  always #5 clk_i = ~clk_i;

  function automatic vec_t mk(input logic rst, clear, load, en, down, clear_wm, alarm_clr,
                              input logic [7:0] delta, d, thresh, q, mx, mn,
                              input logic ovf, udf, alarm);
    vec_t v;
    v.rst = rst; v.clear = clear; v.load = load; v.en = en; v.down = down;
    v.clear_wm = clear_wm; v.alarm_clr = alarm_clr;
    v.delta = delta; v.d = d; v.thresh = thresh;
    v.exp_q = q; v.exp_max = mx; v.exp_min = mn;
    v.exp_ovf = ovf; v.exp_udf = udf; v.exp_alarm = alarm;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    num_checks++;
    if (actual !== expected) begin
      num_fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic idleInputs();
    rst_i       = 1'b0;
    clear_i     = '0;
    load_i      = '0;
    en_i        = '0;
    down_i      = '0;
    clear_wm_i  = '0;
    alarm_clr_i = '0;
    delta_i     = '0;
    d_i         = '0;
    thresh_i    = {NUM_CH{8'hFF}};
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic applyStimulus(input vec_t v);
    idleInputs();
    rst_i          = v.rst;
    clear_i[0]     = v.clear;
    load_i[0]      = v.load;
    en_i[0]        = v.en;
    down_i[0]      = v.down;
    clear_wm_i[0]  = v.clear_wm;
    alarm_clr_i[0] = v.alarm_clr;
    delta_i[7:0]   = v.delta;
    d_i[7:0]       = v.d;
    thresh_i[7:0]  = v.thresh;
    tick();
  endtask

  initial begin
    idleInputs();

    // Columns: rst clr ld en dn cwm aclr | delta d thresh | q max min | ovf udf alarm
    vecs.push_back(mk(1,0,0,0,0,0,0,   0,  0,255,   0,  0,  0, 0,0,0));
    vecs.push_back(mk(1,0,1,0,0,0,0,   0, 99,255,   0,  0,  0, 0,0,0));
    vecs.push_back(mk(0,0,1,0,0,0,0,   0,250,255, 250,250,  0, 0,0,0));
    vecs.push_back(mk(0,0,0,1,0,0,0,  10,  0,255,   4,250,  0, 1,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,   0,  0,255,   4,250,  0, 1,0,0));
    vecs.push_back(mk(0,0,0,1,0,0,0,   0,  0,255,   4,250,  0, 1,0,0));
    vecs.push_back(mk(0,0,1,0,0,0,0,   0,  3,255,   3,250,  0, 0,0,0));
    vecs.push_back(mk(0,0,0,1,1,0,0,   5,  0,255, 254,254,  0, 0,1,0));
    vecs.push_back(mk(0,1,0,0,0,0,0,   0,  0,255,   0,254,  0, 0,0,0));
    vecs.push_back(mk(0,1,0,0,0,1,0,   0,  0,255,   0,  0,  0, 0,0,0));
    vecs.push_back(mk(0,0,1,0,0,0,0,   0,100,255, 100,100,  0, 0,0,0));
    vecs.push_back(mk(0,0,0,1,1,0,0,  60,  0,255,  40,100,  0, 0,0,0));
    vecs.push_back(mk(0,0,0,0,0,1,0,   0,  0,255,  40, 40, 40, 0,0,0));
    vecs.push_back(mk(0,0,0,1,0,0,0,   5,  0,255,  45, 45, 40, 0,0,0));
    vecs.push_back(mk(0,0,0,1,1,0,0,  10,  0,255,  35, 45, 35, 0,0,0));
    vecs.push_back(mk(0,0,1,0,0,0,0,   0, 60, 50,  60, 60, 35, 0,0,1));
    vecs.push_back(mk(0,0,0,1,0,0,1,   5,  0, 50,  65, 65, 35, 0,0,1));
    vecs.push_back(mk(0,0,1,0,0,0,1,   0, 30, 50,  30, 65, 30, 0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,   0,  0, 50,  30, 65, 30, 0,0,0));
    vecs.push_back(mk(0,0,1,0,0,0,0,   0, 55, 50,  55, 65, 30, 0,0,1));
    vecs.push_back(mk(0,0,1,0,0,0,0,   0, 10, 50,  10, 65, 10, 0,0,1));
    vecs.push_back(mk(0,0,0,0,0,0,1,   0,  0, 50,  10, 65, 10, 0,0,0));
    vecs.push_back(mk(0,0,1,0,0,0,0,   0, 50, 50,  50, 65, 10, 0,0,1));
    vecs.push_back(mk(0,0,0,0,0,0,1,   0,  0,255,  50, 65, 10, 0,0,0));
    vecs.push_back(mk(0,0,0,1,1,0,0,  60,  0,255, 246,246, 10, 0,1,0));
    vecs.push_back(mk(1,0,1,0,0,0,0,   0, 99,255,   0,  0,  0, 0,0,0));
    vecs.push_back(mk(0,0,0,1,0,0,0,   7,  0,255,   7,  7,  0, 0,0,0));
    vecs.push_back(mk(0,1,1,1,0,0,0,   3, 77,255,   0,  7,  0, 0,0,0));
    vecs.push_back(mk(0,0,1,1,0,0,0,   3, 77,255,  77, 77,  0, 0,0,0));

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d q", i),     q_w[7:0],   vecs[i].exp_q);
      checkOutput($sformatf("vec%0d max", i),   max_w[7:0], vecs[i].exp_max);
      checkOutput($sformatf("vec%0d min", i),   min_w[7:0], vecs[i].exp_min);
      checkOutput($sformatf("vec%0d ovf", i),   ovf_w[0],   vecs[i].exp_ovf);
      checkOutput($sformatf("vec%0d udf", i),   udf_w[0],   vecs[i].exp_udf);
      checkOutput($sformatf("vec%0d alarm", i), alarm_w[0], vecs[i].exp_alarm);
    end

    // Saturating and pulsed-flag variants on channel 0
    idleInputs(); rst_i = 1'b1; tick();
    idleInputs(); load_i[0] = 1'b1; d_i[7:0] = 8'd3; tick();
    idleInputs(); en_i[0] = 1'b1; down_i[0] = 1'b1; delta_i[7:0] = 8'd5; tick();
    checkOutput("sat down q",   q_s[7:0],   8'd0);
    checkOutput("sat down udf", udf_s[0],   1'b1);
    checkOutput("sat down min", min_s[7:0], 8'd0);
    checkOutput("wrap down q",  q_w[7:0],   8'd254);
    checkOutput("pulse udf",    udf_p[0],   1'b1);
    idleInputs(); load_i[0] = 1'b1; d_i[7:0] = 8'd250; tick();
    checkOutput("sat load clears udf", udf_s[0], 1'b0);
    idleInputs(); en_i[0] = 1'b1; delta_i[7:0] = 8'd10; tick();
    checkOutput("sat up q",   q_s[7:0],   8'd255);
    checkOutput("sat up ovf", ovf_s[0],   1'b1);
    checkOutput("sat up max", max_s[7:0], 8'd255);
    checkOutput("pulse ovf",  ovf_p[0],   1'b1);
    checkOutput("pulse q",    q_p[7:0],   8'd4);
    idleInputs(); tick();
    checkOutput("pulse ovf drops", ovf_p[0], 1'b0);
    checkOutput("sat ovf sticky",  ovf_s[0], 1'b1);
    checkOutput("sat hold q",      q_s[7:0], 8'd255);

    // Channel independence: ch0 loads while ch1 counts down from 7
    idleInputs(); rst_i = 1'b1; tick();
    idleInputs(); load_i[1] = 1'b1; d_i[15:8] = 8'd7; tick();
    checkOutput("ind ch1 load", q_w[15:8], 8'd7);
    checkOutput("ind ch0 idle", q_w[7:0],  8'd0);
    for (int k = 0; k < 3; k++) begin
      idleInputs();
      if (k == 0) begin
        load_i[0] = 1'b1;
        d_i[7:0]  = 8'd200;
      end
      en_i[1]       = 1'b1;
      down_i[1]     = 1'b1;
      delta_i[15:8] = 8'd1;
      tick();
      checkOutput($sformatf("ind ch1 q step%0d", k),   q_w[15:8],   8'(6 - k));
      checkOutput($sformatf("ind ch1 udf step%0d", k), udf_w[1],    1'b0);
      checkOutput($sformatf("ind ch0 q step%0d", k),   q_w[7:0],    8'd200);
      checkOutput($sformatf("ind ch0 max step%0d", k), max_w[7:0],  8'd200);
      checkOutput($sformatf("ind ch2 q step%0d", k),   q_w[23:16],  8'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
    $finish;
  end

endmodule
